// File: rtl/rr_response_router.sv
// rr_response_router
//   Return path of the round-robin PLM scheduling kernel. Each kernel port's
//   grant tag {grant_valid, grant_id} is delayed by PLM_LATENCY cycles so that
//   it lines up with that port's read data. The aligned tag then steers
//   plm_outputs[k] into the issuing consumer's valid/ready response slot.
//
// Ports
//   clk          : sole clock, all state updates on posedge
//   reset        : asynchronous, active-low reset
//   grant_valid  : [NKERNELS]   kernel k carries a read this cycle
//   grant_id     : [NKERNELS]   consumer index granted on kernel k
//   plm_outputs  : [NKERNELS]   read data, valid PLM_LATENCY cycles after grant
//   resp_ready   : [NCONSUMERS] consumer accepts its response
//   responses    : [NCONSUMERS] packed {value, valid}, valid at the LSB
//   overrun      : sticky, an arrival hit a full slot that was not accepted
//   collision    : sticky, two kernels returned data for one consumer at once
module rr_response_router #(
  parameter int NCONSUMERS  = 8,
  parameter int NBANKS      = 4,
  parameter int NPORTS      = 2,
  parameter int VALUE_WIDTH = 8,
  parameter int PLM_LATENCY = 1,
  localparam int NKERNELS   = NBANKS * NPORTS,
  localparam int ID_WIDTH   = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1,
  localparam int RESP_WIDTH = VALUE_WIDTH + 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NKERNELS-1:0]                     grant_valid,
  input  logic [NKERNELS-1:0][ID_WIDTH-1:0]       grant_id,
  input  logic [NKERNELS-1:0][VALUE_WIDTH-1:0]    plm_outputs,
  input  logic [NCONSUMERS-1:0]                   resp_ready,
  output logic [NCONSUMERS-1:0][RESP_WIDTH-1:0]   responses,
  output logic                                    overrun,
  output logic                                    collision
);

  // Tag pipeline: stage 0 captures the grant, stage PLM_LATENCY-1 is aligned
  // with the PLM read data.
  logic [NKERNELS-1:0]               r_tag_valid [PLM_LATENCY];
  logic [NKERNELS-1:0][ID_WIDTH-1:0] r_tag_id    [PLM_LATENCY];

  logic [NCONSUMERS-1:0]                  r_valid;
  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] r_value;
  logic                                   r_overrun;
  logic                                   r_collision;

  logic [NKERNELS-1:0]                    w_last_valid;
  logic [NKERNELS-1:0][ID_WIDTH-1:0]      w_last_id;
  logic [NCONSUMERS-1:0][NKERNELS-1:0]    w_hit;
  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] w_sel_val;
  logic [NCONSUMERS-1:0]                  w_arrival;
  logic [NCONSUMERS-1:0]                  w_multi;
  logic [NCONSUMERS-1:0]                  w_load;
  logic [NCONSUMERS-1:0]                  w_drop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < PLM_LATENCY; s++) begin
        r_tag_valid[s] <= '0;
        r_tag_id[s]    <= '0;
      end
    end else begin
      r_tag_valid[0] <= grant_valid;
      r_tag_id[0]    <= grant_id;
      for (int s = 1; s < PLM_LATENCY; s++) begin
        r_tag_valid[s] <= r_tag_valid[s-1];
        r_tag_id[s]    <= r_tag_id[s-1];
      end
    end
  end

  assign w_last_valid = r_tag_valid[PLM_LATENCY-1];
  assign w_last_id    = r_tag_id[PLM_LATENCY-1];

  // Per-consumer steering. The descending scan leaves the lowest matching
  // kernel's data in w_sel_val. More than one hit bit set means a collision
  // (x & (x-1) is non-zero exactly when two or more bits are set).
  always_comb begin
    w_hit     = '0;
    w_sel_val = '0;
    w_arrival = '0;
    w_multi   = '0;
    for (int c = 0; c < NCONSUMERS; c++) begin
      for (int k = 0; k < NKERNELS; k++) begin
        w_hit[c][k] = w_last_valid[k] && (w_last_id[k] == ID_WIDTH'(c));
      end
      for (int k = NKERNELS - 1; k >= 0; k--) begin
        if (w_hit[c][k]) begin
          w_sel_val[c] = plm_outputs[k];
        end
      end
      w_arrival[c] = |w_hit[c];
      w_multi[c]   = |(w_hit[c] & (w_hit[c] - NKERNELS'(1)));
    end
  end

  // An arrival is taken when the slot is empty or being drained this cycle;
  // otherwise it is lost and flagged.
  assign w_load = w_arrival & (~r_valid | resp_ready);
  assign w_drop = w_arrival & r_valid & ~resp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid     <= '0;
      r_value     <= '0;
      r_overrun   <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      for (int c = 0; c < NCONSUMERS; c++) begin
        if (w_load[c]) begin
          r_valid[c] <= 1'b1;
          r_value[c] <= w_sel_val[c];
        end else if (r_valid[c] && resp_ready[c]) begin
          r_valid[c] <= 1'b0;
        end
      end
      r_overrun   <= r_overrun | (|w_drop);
      r_collision <= r_collision | (|w_multi);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCONSUMERS; gi++) begin : g_resp
      assign responses[gi] = {r_value[gi], r_valid[gi]};
    end
  endgenerate

  assign overrun   = r_overrun;
  assign collision = r_collision;

endmodule

// File: tb/tb_rr_response_router.sv
module tb_rr_response_router;

  localparam int NC  = 8;
  localparam int NB  = 4;
  localparam int NP  = 2;
  localparam int VW  = 8;
  localparam int NK  = NB * NP;
  localparam int IDW = 3;
  localparam int RW  = VW + 1;
  localparam int HIST = 4096;

  logic                     clk;
  logic                     reset;
  logic [NK-1:0]            grant_valid;
  logic [NK-1:0][IDW-1:0]   grant_id;
  logic [NK-1:0][VW-1:0]    plm_outputs;
  logic [NC-1:0]            resp_ready;

  logic [NC-1:0][RW-1:0]    responses1, responses3;
  logic                     overrun1, overrun3, collision1, collision3;

  rr_response_router #(.NCONSUMERS(NC), .NBANKS(NB), .NPORTS(NP),
                       .VALUE_WIDTH(VW), .PLM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .grant_valid(grant_valid), .grant_id(grant_id),
    .plm_outputs(plm_outputs), .resp_ready(resp_ready),
    .responses(responses1), .overrun(overrun1), .collision(collision1));

  rr_response_router #(.NCONSUMERS(NC), .NBANKS(NB), .NPORTS(NP),
                       .VALUE_WIDTH(VW), .PLM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .grant_valid(grant_valid), .grant_id(grant_id),
    .plm_outputs(plm_outputs), .resp_ready(resp_ready),
    .responses(responses3), .overrun(overrun3), .collision(collision3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Every grant is remembered by cycle number. A grant from cycle src is
  // delivered at the end of cycle src+L, unless reset was low in any cycle
  // from src onward.
  logic [NK-1:0]          gv_hist  [HIST];
  logic [NK-1:0][IDW-1:0] gid_hist [HIST];
  int  cyc = 0;
  int  last_low = -1000;
  int  lat [2] = '{1, 3};
  bit        m_valid [2][NC];
  bit [VW-1:0] m_value [2][NC];
  bit        m_ovr [2];
  bit        m_col [2];

  task automatic model_step(input int d);
    int src, hits;
    bit [VW-1:0] val;
    if (!reset) begin
      for (int c = 0; c < NC; c++) begin
        m_valid[d][c] = 1'b0;
        m_value[d][c] = '0;
      end
      m_ovr[d] = 1'b0;
      m_col[d] = 1'b0;
      return;
    end
    src = cyc - lat[d];
    for (int c = 0; c < NC; c++) begin
      hits = 0;
      val  = '0;
      if (src > last_low) begin
        for (int k = 0; k < NK; k++) begin
          if (gv_hist[src % HIST][k] && gid_hist[src % HIST][k] == IDW'(c)) begin
            if (hits == 0) val = plm_outputs[k];
            hits++;
          end
        end
      end
      if (hits > 1) m_col[d] = 1'b1;
      if (hits > 0) begin
        if (!m_valid[d][c] || resp_ready[c]) begin
          m_valid[d][c] = 1'b1;
          m_value[d][c] = val;
        end else begin
          m_ovr[d] = 1'b1;
        end
      end else if (m_valid[d][c] && resp_ready[c]) begin
        m_valid[d][c] = 1'b0;
      end
    end
  endtask

  task automatic cmp(input int d, input logic [NC-1:0][RW-1:0] r,
                     input logic o, input logic col);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("L%0d_valid%0d", lat[d], c), 32'(r[c][0]), 32'(m_valid[d][c]));
      if (m_valid[d][c])
        chk($sformatf("L%0d_value%0d", lat[d], c), 32'(r[c][RW-1:1]), 32'(m_value[d][c]));
    end
    chk($sformatf("L%0d_overrun", lat[d]), 32'(o), 32'(m_ovr[d]));
    chk($sformatf("L%0d_collision", lat[d]), 32'(col), 32'(m_col[d]));
  endtask

  always @(posedge clk) begin
    gv_hist[cyc % HIST]  = grant_valid;
    gid_hist[cyc % HIST] = grant_id;
    if (!reset) last_low = cyc;
    model_step(0);
    model_step(1);
    cyc++;
    #1;
    cmp(0, responses1, overrun1, collision1);
    cmp(1, responses3, overrun3, collision3);
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    grant_valid = '0;
    grant_id    = '0;
  endtask

  initial begin
    reset       = 1'b0;
    grant_valid = '0;
    grant_id    = '0;
    plm_outputs = '0;
    resp_ready  = '1;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // 1: quiet after reset release
    repeat (10) @(negedge clk);
    for (int c = 0; c < NC; c++) chk($sformatf("t1_resp%0d", c), 32'(responses1[c]), 32'd0);
    chk("t1_overrun", 32'(overrun1), 32'd0);
    chk("t1_collision", 32'(collision1), 32'd0);
    $display("test1 quiet: overrun=%0b collision=%0b", overrun1, collision1);

    // 2: single read, kernel 1 -> consumer 3
    grant_valid[1] = 1'b1; grant_id[1] = 3'd3;
    @(negedge clk);
    idle(); plm_outputs[1] = 8'h5A;
    @(negedge clk);
    chk("t2_resp3", 32'(responses1[3]), 32'h0B5);
    for (int c = 0; c < NC; c++)
      if (c != 3) chk($sformatf("t2_other%0d", c), 32'(responses1[c]), 32'd0);
    $display("test2 single: resp3=%h", responses1[3]);
    @(negedge clk);
    chk("t2_resp3_cleared", 32'(responses1[3][0]), 32'd0);

    // 3: two consumers in parallel
    grant_valid[0] = 1'b1; grant_id[0] = 3'd2;
    grant_valid[6] = 1'b1; grant_id[6] = 3'd5;
    @(negedge clk);
    idle(); plm_outputs[0] = 8'h11; plm_outputs[6] = 8'h22;
    @(negedge clk);
    chk("t3_resp2", 32'(responses1[2]), 32'h023);
    chk("t3_resp5", 32'(responses1[5]), 32'h045);
    chk("t3_collision", 32'(collision1), 32'd0);
    $display("test3 parallel: resp2=%h resp5=%h", responses1[2], responses1[5]);

    // 4: backpressure and overrun on consumer 4
    resp_ready[4] = 1'b0;
    grant_valid[0] = 1'b1; grant_id[0] = 3'd4;
    @(negedge clk);
    plm_outputs[0] = 8'h33;
    @(negedge clk);
    idle(); plm_outputs[0] = 8'h44;
    @(negedge clk);
    chk("t4_resp4_held", 32'(responses1[4]), 32'h067);
    chk("t4_overrun", 32'(overrun1), 32'd1);
    $display("test4 backpressure: resp4=%h overrun=%0b", responses1[4], overrun1);
    resp_ready[4] = 1'b1;
    @(negedge clk);
    chk("t4_resp4_drained", 32'(responses1[4][0]), 32'd0);

    // 5: collision on consumer 7, lowest kernel wins
    grant_valid[2] = 1'b1; grant_id[2] = 3'd7;
    grant_valid[3] = 1'b1; grant_id[3] = 3'd7;
    @(negedge clk);
    idle(); plm_outputs[2] = 8'h01; plm_outputs[3] = 8'h02;
    @(negedge clk);
    chk("t5_resp7", 32'(responses1[7]), 32'h003);
    chk("t5_collision", 32'(collision1), 32'd1);
    $display("test5 collision: resp7=%h collision=%0b", responses1[7], collision1);

    // 6: reset mid-latency on the latency-3 instance
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    grant_valid[1] = 1'b1; grant_id[1] = 3'd3;
    @(negedge clk);
    idle();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < NK; k++) plm_outputs[k] = 8'hA5;
    repeat (6) @(negedge clk);
    for (int c = 0; c < NC; c++) chk($sformatf("t6_resp%0d", c), 32'(responses3[c]), 32'd0);
    chk("t6_overrun", 32'(overrun3), 32'd0);
    chk("t6_collision", 32'(collision3), 32'd0);
    $display("test6 reset flush: resp3=%h", responses3[3]);

    // random traffic with occasional resets and variable backpressure
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 79) != 0) ? 1'b1 : 1'b0;
      for (int k = 0; k < NK; k++) begin
        grant_valid[k] = ($urandom_range(0, 99) < 20);
        grant_id[k]    = IDW'($urandom_range(0, NC - 1));
        plm_outputs[k] = VW'($urandom);
      end
      for (int c = 0; c < NC; c++)
        resp_ready[c] = ($urandom_range(0, 99) < ((n < 300) ? 85 : 35));
      if (n % 100 == 0)
        $display("random cycle %0d: grants=%b ready=%b", n, grant_valid, resp_ready);
    end
    @(negedge clk);
    idle();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/rr_response_router.md
Name: rr_response_router

Overview:
- Return path of the round-robin PLM scheduling kernel. It routes read data from the NBANKS*NPORTS PLM ports back to the consumer that issued each read.
- The scheduler tells this block which consumer it granted on each kernel port. The block delays that tag by the PLM read latency, then uses it to steer read data into a per-consumer response register.
- The per-consumer response register uses a valid/ready handshake. It sits alongside rr_scheduling_kernel, between the PLM bank outputs and the consumers.

Parameters:
- NCONSUMERS, 8, number of requesting consumers.
- NBANKS, 4, number of PLM banks.
- NPORTS, 2, ports per bank.
- VALUE_WIDTH, 8, data word width.
- PLM_LATENCY, 1, PLM read latency in cycles; must be >= 1.
- Derived: NKERNELS = NBANKS*NPORTS. ID_WIDTH = $clog2(NCONSUMERS). RESP_WIDTH = VALUE_WIDTH+1.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- grant_valid[NKERNELS]  in  1 each  kernel k carries a read this cycle; aligned with plm_inputs[k].
- grant_id[NKERNELS]  in  ID_WIDTH each  consumer index granted on kernel k.
- plm_outputs[NKERNELS]  in  VALUE_WIDTH each  PLM read data, valid PLM_LATENCY cycles after the grant.
- resp_ready[NCONSUMERS]  in  1 each  consumer accepts its response.
- responses[NCONSUMERS]  out  RESP_WIDTH each  packed {value, valid}, with valid at the LSB.
- overrun  out  1  sticky: a response arrived while the slot was full and not accepted.
- collision  out  1  sticky: two kernels returned data for the same consumer in one cycle.

Behaviour:
- Reset (reset=0, asynchronous): clears all tag pipeline stages, all responses (value=0, valid=0), overrun and collision. In-flight reads are dropped; no response is produced after reset releases.
- Tag pipeline, per kernel: PLM_LATENCY registered stages of {grant_valid, grant_id}.
  - A grant present during cycle c appears at the last stage during cycle c+PLM_LATENCY.
  - This aligns the tag with plm_outputs[k].
  - Write or idle grants are driven with grant_valid=0 by the scheduler and never produce a response.
- Arrival: during cycle c+PLM_LATENCY, "arrival[k] for consumer i" means the last stage of kernel k is valid with id=i.
- Steering, per consumer c: sel = lowest k with arrival for consumer c.
  - If more than one k matches, sel wins, the others are discarded, and collision is set at the next posedge.
- Response slot update at posedge, per consumer c (slot fields are valid and value):
  - No arrival, valid=1, resp_ready=1: valid is cleared.
  - No arrival, otherwise: the slot holds.
  - Arrival, valid=0 or resp_ready=1: the slot loads value=plm_outputs[sel] and valid=1. A simultaneous accept and new arrival keeps valid high with the new value.
  - Arrival, valid=1 and resp_ready=0: the arrival is dropped, the slot holds the old value, and overrun is set.
- Latency: a grant in cycle c produces responses[i] valid during cycle c+PLM_LATENCY+1, i.e. PLM_LATENCY+1 posedges after it.
- When valid=0, the value field holds its last loaded value. Only valid is meaningful; the bench checks the value field only when valid=1.
- overrun and collision stay high until reset.
- Back-to-back grants to the same consumer are supported. With resp_ready held high, responses stream one per cycle with no bubbles.
- Kernels are independent. Different consumers served on different kernels in the same cycle all complete in parallel.

Test Plan:
1. Reset release, no grants: all responses, overrun and collision stay 0 for 10 cycles.
2. PLM_LATENCY=1. Grant on kernel 1, id=3. plm_outputs[1]=0x5A one cycle later. resp_ready[3]=1 → responses[3]={0x5A,1} valid exactly 2 posedges after the grant, for one cycle; all other slots stay 0.
3. Same cycle: kernel 0→id 2 returns 0x11, kernel 6→id 5 returns 0x22 → responses[2]={0x11,1} and responses[5]={0x22,1} in the same cycle; collision=0.
4. Backpressure, resp_ready[4]=0. Read returns 0x33 for id 4, then a second read returns 0x44 for id 4 → slot stays {0x33,1} and overrun=1. Raise resp_ready[4] → valid clears on the next posedge.
5. Kernels 2 and 3 both return for id 7 in one cycle (0x01 and 0x02) → responses[7] value=0x01, collision=1.
6. Grant issued, then reset pulsed low mid-latency (PLM_LATENCY=3) → no response appears after release; all outputs read 0.
